// File: rtl/pkg_perifericos.sv
// Definitions shared by the peripheral-bus registers (button input, LED output).
package pkg_perifericos;

  localparam int PERIF_DW  = 32;
  localparam int N_BTN_DEF = 4;

  localparam logic SEL_NIVEL   = 1'b0;
  localparam logic SEL_EVENTOS = 1'b1;

endpackage : pkg_perifericos

// File: rtl/antirrebote.sv
// One-bit button conditioner: 2-FF synchroniser followed by a stability counter.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic stable_o
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q,   sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          btn_s;

  assign btn_s = sync_q[1];

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    sync_d   = {sync_q[0], btn_i};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (btn_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = btn_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule : antirrebote

// File: rtl/registro_botones.sv
// Push-button input register: debounced levels, sticky press events (W1C) and an event interrupt.
module registro_botones
  import pkg_perifericos::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clck_i,
  input  logic                rst_i,
  input  logic [N_BTN-1:0]    btn_i,
  input  logic                re_i,
  input  logic                sel_i,
  input  logic                we_i,
  input  logic [PERIF_DW-1:0] data_i,
  output logic [PERIF_DW-1:0] data_o,
  output logic                irq_o
);

  logic [N_BTN-1:0]    stable;
  logic [N_BTN-1:0]    rise;
  logic [N_BTN-1:0]    clr_mask;
  logic [N_BTN-1:0]    stable_prev_q, stable_prev_d;
  logic [N_BTN-1:0]    events_q,      events_d;
  logic [PERIF_DW-1:0] data_q,        data_d;
  logic                irq_q,         irq_d;

  for (genvar k = 0; k < N_BTN; k++) begin : g_btn
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
      .clck_i   (clck_i),
      .rst_i    (rst_i),
      .btn_i    (btn_i[k]),
      .stable_o (stable[k])
    );
  end

  if (N_BTN < PERIF_DW) begin : g_mask_unused
    logic data_unused;
    assign data_unused = ^data_i[PERIF_DW-1:N_BTN];
  end

  assign clr_mask = data_i[N_BTN-1:0] & {N_BTN{we_i}};

  always_comb begin
    stable_prev_d = stable;
    rise          = stable & ~stable_prev_q;
    // A press edge in the same cycle as its clear keeps the flag set.
    events_d      = rise | (events_q & ~clr_mask);
    irq_d         = |events_d;
    data_d        = data_q;
    if (re_i) begin
      data_d             = '0;
      data_d[N_BTN-1:0]  = (sel_i == SEL_EVENTOS) ? events_q : stable;
    end
  end

  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      stable_prev_q <= '0;
      events_q      <= '0;
      data_q        <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable_prev_d;
      events_q      <= events_d;
      data_q        <= data_d;
      irq_q         <= irq_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule : registro_botones
